qspi_sram_arbiter: RTL and testbench
====================================

Name: qspi_sram_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the QSPIShifter SRAM datapath. It accepts word read/write requests from two independent requesters (port 0, port 1), grants one at a time, and drives the shifter's re/we/address/data_in strobes. It tracks completion through the shifter's cs_n and returns read data or a timeout error to the granted requester. Sits between the core-side bus masters and the single QSPIShifter instance.

Parameters:
AW, 32, address width for requesters and the shifter.
DW, 32, data width for requesters and the shifter.
TIMEOUT, 64, max cycles in ISSUE waiting for shf_cs_n to fall; also max cycles in BUSY waiting for shf_cs_n to rise. Must be ≥2.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  port 0 request; held until m0_ack or m0_err
m0_we  in  1  port 0 write (1) / read (0); stable while m0_req
m0_addr  in  AW  port 0 word address
m0_wdata  in  DW  port 0 write data
m0_ack  out  1  one-cycle pulse: port 0 transaction done
m0_err  out  1  one-cycle pulse: port 0 transaction timed out
m0_rdata  out  DW  port 0 read data, valid in the m0_ack cycle, held until next port 0 ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as port 0 for port 1
shf_re  out  1  to shifter re
shf_we  out  1  to shifter we
shf_address  out  AW  to shifter address
shf_data_in  out  DW  to shifter data_in
shf_cs_n  in  1  from shifter cs_n (low = transaction on the wire)
shf_data_out  in  DW  from shifter data_out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; shf_re=shf_we=0; shf_address=shf_data_in=0; m*_ack=m*_err=0; m*_rdata=0; last_grant=1 (port 0 wins the first tie); timer=0. Reset mid-transaction aborts immediately; no ack/err is issued for the aborted request.
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE: when any m*_req is sampled high, pick the winner: a single requester wins; if both request, the port != last_grant wins. Register winner, we, addr, and wdata into shf_* in that cycle; set last_grant=winner; go to ISSUE. The next cycle shows shf_re (read) or shf_we (write) high. Exactly one of shf_re/shf_we is ever high.
- ISSUE: hold the strobe, address and data stable. On shf_cs_n==0, go to BUSY and clear the timer. If the timer reaches TIMEOUT-1 with no fall, drop the strobes and go to DONE with error flagged.
- BUSY: keep the strobe asserted while cs_n is low. On shf_cs_n==1, deassert shf_re/shf_we in the same cycle, capture shf_data_out for reads, and go to DONE. A timeout here also goes to DONE with error flagged.
- DONE: pulse the winner's ack, or its err if flagged, for exactly one cycle, then return to IDLE. rdata updates only on a read ack; writes and errors leave rdata unchanged.
- Arbitration is non-preemptive. A request arriving during a transaction waits. The earliest new grant is in the cycle after DONE, so with back-to-back requests the idle gap between strobes is ≥2 cycles.
- A requester dropping req before ack is a protocol violation. The arbiter still completes the transaction and pulses ack.
- Timer: saturating counter of width clog2(TIMEOUT)+1. It is cleared on every state entry.
- The non-granted port's ack and err stay 0 throughout.

Test Plan:
- Reset, then m0 read addr=111, with a shifter model pulling cs_n low 3 cycles after re and high 10 cycles later with data_out=0xDEADBEEF → shf_re high for the whole transaction and dropped on cs_n rise; m0_ack pulses once; m0_rdata=0xDEADBEEF; m1_ack stays 0.
- m1 write addr=333 data=100 → shf_we=1, shf_address=333, shf_data_in=100 stable until cs_n rises; m1_ack pulses once; m1_rdata unchanged.
- m0 and m1 request in the same cycle, then re-request continuously for 4 transactions → grant order m0, m1, m0, m1; both ports see 2 acks each.
- Shifter model never drops cs_n, TIMEOUT=64 → after 64 ISSUE cycles the strobes drop and m0_err pulses once; m0_ack stays 0; state returns to IDLE (busy=0).
- Reset asserted for one cycle during BUSY → next cycle shf_re=shf_we=0, busy=0, no ack/err; a fresh m1 request afterwards is granted (last_grant reset) and completes normally.
- Read followed by a write on the same port → rdata holds the read value across the write ack.

Source files
------------

// File: rtl/qspi_sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// qspi_sram_arbiter_if
// Bus bundle between the two core-side requesters, the arbiter and the
// QSPIShifter SRAM datapath.
//   m0_* / m1_*      : requester ports (req/we/addr/wdata in, ack/err/rdata out)
//   shf_*            : shifter strobes, address, data and completion (cs_n)
//   busy             : arbiter is not idle
// Modports:
//   slave  - the arbiter's view (receives requests, drives the shifter)
//   master - the environment's view (requesters plus shifter)
// -----------------------------------------------------------------------------
interface qspi_sram_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_ack;
   logic          m0_err;
   logic [DW-1:0] m0_rdata;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_ack;
   logic          m1_err;
   logic [DW-1:0] m1_rdata;

   logic          shf_re;
   logic          shf_we;
   logic [AW-1:0] shf_address;
   logic [DW-1:0] shf_data_in;
   logic          shf_cs_n;
   logic [DW-1:0] shf_data_out;

   logic          busy;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  shf_cs_n, shf_data_out,
      output m0_ack, m0_err, m0_rdata,
      output m1_ack, m1_err, m1_rdata,
      output shf_re, shf_we, shf_address, shf_data_in,
      output busy
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output shf_cs_n, shf_data_out,
      input  m0_ack, m0_err, m0_rdata,
      input  m1_ack, m1_err, m1_rdata,
      input  shf_re, shf_we, shf_address, shf_data_in,
      input  busy
   );
endinterface

// File: rtl/qspi_sram_arbiter.sv
// -----------------------------------------------------------------------------
// qspi_sram_arbiter
// Two-port round-robin arbiter and sequencer in front of the QSPIShifter.
// One word read or write is granted at a time; the shifter strobe is held
// until cs_n has fallen and risen again (or a wait times out), then the
// winner receives a one-cycle ack (with read data) or err pulse.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - qspi_sram_arbiter_if.slave: requesters, shifter and busy
// Parameters:
//   AW, DW   - address / data width
//   TIMEOUT  - max cycles waiting for cs_n to fall (ISSUE) or rise (BUSY), >= 2
// -----------------------------------------------------------------------------
module qspi_sram_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input logic                clk,
   input logic                reset,
   qspi_sram_arbiter_if.slave bus
);

   localparam int            TW   = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TSAT = {TW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          last_grant_q, last_grant_d;
   logic          win_q, win_d;          // 0 = port 0, 1 = port 1
   logic          op_we_q, op_we_d;      // latched direction of the granted op
   logic          re_q, re_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d;
   logic          err0_q, err0_d, err1_q, err1_d;
   logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic          busy_q, busy_d;

   logic          any_req_s;
   logic          grant1_s;
   logic          timeout_s;

   assign any_req_s = bus.m0_req | bus.m1_req;
   // Port 1 wins when alone, or on a tie when port 0 had the last grant.
   assign grant1_s  = bus.m1_req & (~bus.m0_req | ~last_grant_q);
   assign timeout_s = (timer_q == TMAX);

   // State and output registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         last_grant_q <= 1'b1;
         win_q        <= 1'b0;
         op_we_q      <= 1'b0;
         re_q         <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         last_grant_q <= last_grant_d;
         win_q        <= win_d;
         op_we_q      <= op_we_d;
         re_q         <= re_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic; cs_n is checked before the timer so an edge seen on
   // the last allowed cycle still counts as success.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (!bus.shf_cs_n) begin
               state_d = ST_BUSY;
            end else if (timeout_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_BUSY: begin
            if (bus.shf_cs_n || timeout_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath
   always_comb begin
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (timer_q == TSAT) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + TW'(1);
      end

      last_grant_d = last_grant_q;
      win_d        = win_q;
      op_we_d      = op_we_q;
      re_d         = re_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      busy_d       = (state_d != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               win_d        = grant1_s;
               last_grant_d = grant1_s;
               if (grant1_s) begin
                  op_we_d = bus.m1_we;
                  addr_d  = bus.m1_addr;
                  wdata_d = bus.m1_wdata;
               end else begin
                  op_we_d = bus.m0_we;
                  addr_d  = bus.m0_addr;
                  wdata_d = bus.m0_wdata;
               end
               re_d = ~op_we_d;
               we_d = op_we_d;
            end else begin
               win_d = win_q;
            end
         end
         ST_ISSUE: begin
            if (bus.shf_cs_n && timeout_s) begin
               re_d   = 1'b0;
               we_d   = 1'b0;
               err0_d = ~win_q;
               err1_d = win_q;
            end else begin
               win_d = win_q;
            end
         end
         ST_BUSY: begin
            if (bus.shf_cs_n) begin
               re_d   = 1'b0;
               we_d   = 1'b0;
               ack0_d = ~win_q;
               ack1_d = win_q;
               // Read data is captured on the cs_n rise and shown with ack.
               if (!op_we_q && !win_q) begin
                  rdata0_d = bus.shf_data_out;
               end else if (!op_we_q && win_q) begin
                  rdata1_d = bus.shf_data_out;
               end else begin
                  rdata0_d = rdata0_q;
               end
            end else if (timeout_s) begin
               re_d   = 1'b0;
               we_d   = 1'b0;
               err0_d = ~win_q;
               err1_d = win_q;
            end else begin
               win_d = win_q;
            end
         end
         ST_DONE: win_d = win_q;
         default: win_d = win_q;
      endcase
   end

   assign bus.shf_re      = re_q;
   assign bus.shf_we      = we_q;
   assign bus.shf_address = addr_q;
   assign bus.shf_data_in = wdata_q;
   assign bus.m0_ack      = ack0_q;
   assign bus.m0_err      = err0_q;
   assign bus.m0_rdata    = rdata0_q;
   assign bus.m1_ack      = ack1_q;
   assign bus.m1_err      = err1_q;
   assign bus.m1_rdata    = rdata1_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_qspi_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qspi_sram_arbiter
// Self-checking bench for qspi_sram_arbiter. A transaction-level model
// predicts, for each grant, how many cycles the strobe stays up (from the
// shifter delays the bench itself chooses) and whether it ends in ack or err;
// every cycle the DUT outputs are compared against that prediction.
// -----------------------------------------------------------------------------
module tb_qspi_sram_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   qspi_sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   qspi_sram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // requester side
   logic        rq       [2];
   logic        rq_we    [2];
   logic [31:0] rq_addr  [2];
   logic [31:0] rq_wdata [2];
   int          req_pct   = 0;
   int          reqs_left = 0;

   // shifter side
   logic        cs_n = 1'b1;
   logic [31:0] dout = 32'h0;

   // transaction model: a granted op shows its strobe for cycles 0..dlen-1
   // and ack/err in cycle dlen; cs_n is low in cycles f_dly..f_dly+l_len-1
   bit          act = 1'b0;
   int          cyc, dlen, f_dly, l_len;
   bit          m_port, m_we, m_err, last_g, just_reset;
   logic [31:0] m_addr, m_wdata, m_rdval;
   logic [31:0] exp_rdata [2];
   int          force_f = -1;
   int          force_l = -1;
   bit          force_rd_en = 1'b0;
   logic [31:0] force_rd = 32'h0;
   int          dut_acks [2];
   int          dut_errs [2];
   bit          glog [$];

   task automatic chk1(input string name, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0b want=%0b t=%0t", name, got, want, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   task automatic apply();
      bus.m0_req   = rq[0];
      bus.m0_we    = rq_we[0];
      bus.m0_addr  = rq_addr[0];
      bus.m0_wdata = rq_wdata[0];
      bus.m1_req   = rq[1];
      bus.m1_we    = rq_we[1];
      bus.m1_addr  = rq_addr[1];
      bus.m1_wdata = rq_wdata[1];
      bus.shf_cs_n     = cs_n;
      bus.shf_data_out = dout;
   endtask

   task automatic advance_model();
      int r;
      just_reset = 1'b0;
      if (reset) begin
         act = 1'b0; last_g = 1'b1; just_reset = 1'b1;
         m_addr = 32'h0; m_wdata = 32'h0;
         exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
      end else if (act) begin
         cyc++;
         if (cyc > dlen) act = 1'b0;
      end else if (rq[0] || rq[1]) begin
         if (rq[0] && rq[1]) m_port = !last_g;
         else                m_port = rq[1];
         last_g = m_port;
         glog.push_back(m_port);
         m_we    = rq_we[m_port];
         m_addr  = rq_addr[m_port];
         m_wdata = rq_wdata[m_port];
         if (force_f >= 0) f_dly = force_f;
         else begin
            r = $urandom_range(0, 49);
            f_dly = (r == 0) ? TO : (r == 1) ? TO - 1 : $urandom_range(0, 6);
         end
         if (force_l >= 0) l_len = force_l;
         else begin
            r = $urandom_range(0, 49);
            l_len = (r == 0) ? TO + 1 : (r == 1) ? TO : $urandom_range(1, 8);
         end
         m_rdval = force_rd_en ? force_rd : $urandom;
         if (f_dly >= TO)      begin dlen = TO;             m_err = 1'b1; end
         else if (l_len > TO)  begin dlen = f_dly + TO + 1; m_err = 1'b1; end
         else                  begin dlen = f_dly + l_len + 1; m_err = 1'b0; end
         act = 1'b1; cyc = 0;
      end
      if (act && cyc == dlen && !m_err && !m_we) exp_rdata[m_port] = m_rdval;
   endtask

   task automatic check();
      bit strobe, done;
      strobe = act && (cyc < dlen);
      done   = act && (cyc == dlen);
      chk1("busy",   bus.busy,   act);
      chk1("shf_re", bus.shf_re, strobe && !m_we);
      chk1("shf_we", bus.shf_we, strobe && m_we);
      if (strobe || just_reset) begin
         chk32("shf_address", bus.shf_address, m_addr);
         chk32("shf_data_in", bus.shf_data_in, m_wdata);
      end
      chk1("m0_ack", bus.m0_ack, done && !m_err && !m_port);
      chk1("m1_ack", bus.m1_ack, done && !m_err && m_port);
      chk1("m0_err", bus.m0_err, done && m_err && !m_port);
      chk1("m1_err", bus.m1_err, done && m_err && m_port);
      chk32("m0_rdata", bus.m0_rdata, exp_rdata[0]);
      chk32("m1_rdata", bus.m1_rdata, exp_rdata[1]);
      if (bus.m0_ack) dut_acks[0]++;
      if (bus.m1_ack) dut_acks[1]++;
      if (bus.m0_err) dut_errs[0]++;
      if (bus.m1_err) dut_errs[1]++;
   endtask

   task automatic update_requesters();
      for (int p = 0; p < 2; p++) begin
         if (act && cyc == dlen && int'(m_port) == p) rq[p] = 1'b0;
         if (!rq[p] && reqs_left > 0 && int'($urandom_range(0, 99)) < req_pct) begin
            reqs_left--;
            rq[p]       = 1'b1;
            rq_we[p]    = 1'($urandom_range(0, 1));
            rq_addr[p]  = $urandom;
            rq_wdata[p] = $urandom;
         end
      end
   endtask

   task automatic drive_shifter();
      if (act && cyc < dlen && cyc >= f_dly && cyc < f_dly + l_len) cs_n = 1'b0;
      else                                                           cs_n = 1'b1;
      if (act && cyc >= f_dly + l_len) dout = m_rdval;
      else                             dout = $urandom;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      advance_model();
      check();
      update_requesters();
      drive_shifter();
      apply();
   endtask

   task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
      rq[p] = 1'b1; rq_we[p] = we; rq_addr[p] = addr; rq_wdata[p] = wdata;
      apply();
   endtask

   task automatic run_to_idle(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (!act && !rq[0] && !rq[1] && reqs_left == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk1({name, "_drain"}, ok, 1'b1);
   endtask

   initial begin
      int a0, a1, e0, e1;
      logic [31:0] v;
      for (int p = 0; p < 2; p++) begin
         rq[p] = 1'b0; rq_we[p] = 1'b0; rq_addr[p] = 32'h0; rq_wdata[p] = 32'h0;
         dut_acks[p] = 0; dut_errs[p] = 0; exp_rdata[p] = 32'h0;
      end
      apply();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // m0 read, cs_n falls 3 cycles after re, rises 10 later
      force_f = 3; force_l = 10; force_rd_en = 1'b1; force_rd = 32'hDEAD_BEEF;
      set_req(0, 1'b0, 32'd111, 32'd0);
      run_to_idle("t1", 200);
      chk32("t1_len", 32'(dlen), 32'd14);
      chk32("t1_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
      chk32("t1_acks0", 32'(dut_acks[0]), 32'd1);
      chk32("t1_acks1", 32'(dut_acks[1]), 32'd0);
      force_f = -1; force_l = -1; force_rd_en = 1'b0;

      // m1 write
      set_req(1, 1'b1, 32'd333, 32'd100);
      run_to_idle("t2", 200);
      chk32("t2_acks1", 32'(dut_acks[1]), 32'd1);
      chk32("t2_rdata1", bus.m1_rdata, 32'd0);

      // simultaneous requests, continuous re-request: 4 grants alternate
      glog.delete();
      a0 = dut_acks[0] + dut_errs[0]; a1 = dut_acks[1] + dut_errs[1];
      force_f = 2; force_l = 3;
      rq[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = 32'd10; rq_wdata[0] = 32'd0;
      req_pct = 100; reqs_left = 2;
      set_req(1, 1'b1, 32'd20, 32'd5);
      run_to_idle("t3", 400);
      req_pct = 0;
      chk32("t3_grants", 32'(glog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < glog.size()) chk1("t3_order", glog[i], 1'(i % 2));
      end
      chk32("t3_done0", 32'(dut_acks[0] + dut_errs[0] - a0), 32'd2);
      chk32("t3_done1", 32'(dut_acks[1] + dut_errs[1] - a1), 32'd2);

      // shifter never answers: err after TIMEOUT issue cycles
      a0 = dut_acks[0]; e0 = dut_errs[0];
      force_f = 1000; force_l = 1;
      set_req(0, 1'b0, 32'd44, 32'd0);
      run_to_idle("t4", 200);
      chk32("t4_len", 32'(dlen), 32'd64);
      chk32("t4_errs0", 32'(dut_errs[0] - e0), 32'd1);
      chk32("t4_acks0", 32'(dut_acks[0] - a0), 32'd0);
      chk1("t4_busy", bus.busy, 1'b0);

      // reset in the middle of BUSY
      force_f = 2; force_l = 20;
      set_req(0, 1'b0, 32'd66, 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk1("t5_in_busy", bus.busy, 1'b1);
      a0 = dut_acks[0]; e0 = dut_errs[0]; a1 = dut_acks[1]; e1 = dut_errs[1];
      reset = 1'b1; rq[0] = 1'b0; apply();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk32("t5_no_done", 32'(dut_acks[0] + dut_errs[0] + dut_acks[1] + dut_errs[1]),
            32'(a0 + e0 + a1 + e1));
      force_f = -1; force_l = -1;
      set_req(1, 1'b0, 32'd555, 32'd0);
      run_to_idle("t5", 200);
      chk1("t5_winner", glog[glog.size() - 1], 1'b1);

      // read then write on port 0: rdata holds the read value
      force_f = 1; force_l = 2; force_rd_en = 1'b1; force_rd = 32'h1234_5678;
      set_req(0, 1'b0, 32'd7, 32'd0);
      run_to_idle("t6r", 200);
      force_rd_en = 1'b0;
      set_req(0, 1'b1, 32'd8, 32'd99);
      run_to_idle("t6w", 200);
      v = 32'h1234_5678;
      chk32("t6_rdata", bus.m0_rdata, v);
      force_f = -1; force_l = -1;

      // randomized traffic
      req_pct = 30; reqs_left = 300;
      run_to_idle("rand", 40000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
